ttm4_sequencer: RTL and testbench
=================================

Name: ttm4_sequencer

Overview:
Fetch/execute controller for the TTM4 core. Owns the program counter and return stack and fetches instructions from program ROM over a req/ack handshake. Presents the latched instruction word to the instruction decoder, then uses the decoder's jump, skip and stack controls to compute the next PC. Generates the single store strobe that qualifies register writes. Supports free-run and single-step operation.

Parameters:
PC_W, 8, program counter / ROM address width
IR_W, 11, instruction width; IR[10:6]=OP, IR[5:3]=LR, IR[2:0]=SR
STACK_DEPTH, 4, return-stack entries (power of 2, >=2)
ROM_TO, 15, fetch timeout in cycles (used only with the optional feature)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
RUN  in  1  level; 1 = continuous execution
STEP  in  1  single-step request; acted on at its rising edge
ROM_ADDR  out  PC_W  fetch address (= PC)
ROM_REQ  out  1  fetch request
ROM_ACK  in  1  ROM_DATA valid this cycle
ROM_DATA  in  IR_W  instruction word
IR  out  IR_W  latched instruction, to decoder OP/LR/SR
nPC_LD  in  1  from decoder; 0 = jump
nSK_EN  in  1  from decoder; 0 = conditional-skip instruction
SKIP_COND  in  1  flag condition for skip (1 = skip next)
CALL  in  1  push return address and jump
RET  in  1  pop return address
JUMP_ADDR  in  PC_W  jump / call target
ST_STB  out  1  one-cycle register-store qualifier
BUSY  out  1  1 in any state other than IDLE
STK_ERR  out  1  sticky overflow/underflow flag
TIMEOUT  out  1  sticky fetch timeout flag (constant 0 without the feature)

Behaviour:
- Reset (asynchronous): state=IDLE, PC=0, SP=0, IR=0, ROM_REQ=0, ST_STB=0, STK_ERR=0, TIMEOUT=0, STEP edge register=0. Stack contents are don't-care.
- State machine: IDLE, FETCH, DECODE, EXEC.
- IDLE -> FETCH when RUN=1 or a STEP rising edge is detected. RUN takes precedence. A STEP edge seen in any other state is ignored, not queued.
- FETCH:
  - ROM_REQ=1 and ROM_ADDR=PC.
  - On the first edge with ROM_ACK=1: IR<=ROM_DATA, ROM_REQ drops, go to DECODE.
  - ROM_ACK is ignored while ROM_REQ=0.
- DECODE: one cycle so the decoder outputs can settle. IR is held.
- EXEC:
  - ST_STB=1 for exactly this cycle. The PC is updated at the end of the cycle.
  - Then go to FETCH if RUN=1, otherwise to IDLE. Deasserting RUN mid-instruction always completes the current instruction.
- Minimum instruction time is 3 cycles (when ACK arrives in the first FETCH cycle).
- Next-PC priority, all arithmetic modulo 2^PC_W (wrap from max to 0):
  1. RET: PC<=stack[SP-1], SP--. If SP==0: PC<=PC+1, STK_ERR<=1, SP unchanged.
  2. CALL: stack[SP]<=PC+1, SP++, PC<=JUMP_ADDR. If SP==STACK_DEPTH: no push, jump still taken, STK_ERR<=1.
  3. nPC_LD=0: PC<=JUMP_ADDR.
  4. nSK_EN=0 and SKIP_COND=1: PC<=PC+2.
  5. Otherwise: PC<=PC+1.
- When RET and CALL are both asserted, RET wins and CALL is ignored.
- nPC_LD, nSK_EN, CALL, RET and SKIP_COND are sampled only in EXEC.
- STK_ERR and TIMEOUT clear only on RST.
- A mid-operation reset aborts any fetch immediately: ROM_REQ=0 asynchronously.

Optional Feature:
- SEQ_ROM_TIMEOUT_EN defined:
  - A counter runs in FETCH.
  - If ROM_ACK is still absent after ROM_TO consecutive FETCH cycles: TIMEOUT<=1, ROM_REQ drops, state goes to IDLE, PC and IR are unchanged.
  - Further operation is blocked until RST (RUN/STEP are ignored while TIMEOUT=1).
- Not defined: FETCH waits for ROM_ACK indefinitely, TIMEOUT is tied to 0, and ROM_TO is unused.

Test Plan:
- Reset then RUN=1, ROM_ACK immediate, NOP instructions (all controls inactive) -> ROM_ADDR 0,1,2..., one ST_STB every 3 cycles. From PC=8'hFF the next fetch address is 0.
- RUN=0, one STEP pulse -> exactly one FETCH/DECODE/EXEC, PC 0->1, BUSY low afterwards. Holding STEP high for 10 cycles -> still only one instruction.
- At PC=5, EXEC with nSK_EN=0 and SKIP_COND=1 -> next ROM_ADDR=7. Same case with SKIP_COND=0 -> next ROM_ADDR=6.
- CALL to 0x40 at PC=0x10, then RET -> fetches at 0x40 then 0x11. Five nested CALLs with depth 4 -> STK_ERR=1 on the fifth and the jump is still taken. RET with the stack empty -> PC+1 and STK_ERR=1.
- ROM_ACK delayed 4 cycles -> ROM_REQ held for 4 cycles and IR takes ROM_DATA from the ACK cycle. Asserting RST during FETCH -> ROM_REQ=0 immediately and PC=0.
- With SEQ_ROM_TIMEOUT_EN and ACK never asserted -> TIMEOUT=1 after 15 FETCH cycles, state returns to IDLE, and a subsequent STEP is ignored.

Source files
------------

// File: rtl/ttm4_sequencer.sv
// rtl/ttm4_sequencer.sv - TTM4 fetch/decode/execute sequencer with PC, return stack and store strobe
// Optional ROM fetch timeout is enabled by defining SEQ_ROM_TIMEOUT_EN.
module ttm4_sequencer #(
    parameter int PC_W        = 8,
    parameter int IR_W        = 11,
    parameter int STACK_DEPTH = 4,
    parameter int ROM_TO      = 15
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            RUN,
    input  logic            STEP,
    output logic [PC_W-1:0] ROM_ADDR,
    output logic            ROM_REQ,
    input  logic            ROM_ACK,
    input  logic [IR_W-1:0] ROM_DATA,
    output logic [IR_W-1:0] IR,
    input  logic            nPC_LD,
    input  logic            nSK_EN,
    input  logic            SKIP_COND,
    input  logic            CALL,
    input  logic            RET,
    input  logic [PC_W-1:0] JUMP_ADDR,
    output logic            ST_STB,
    output logic            BUSY,
    output logic            STK_ERR,
    output logic            TIMEOUT
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DECODE = 2'd2,
        EXEC   = 2'd3
    } state_t;

    state_t          state;
    state_t          nextState;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] nextPc;
    logic [PC_W-1:0] pcInc;
    logic [SP_W-1:0] sp;
    logic [SP_W-1:0] nextSp;
    logic [SP_W-1:0] spDec;
    logic [PC_W-1:0] stack [STACK_DEPTH];
    logic [IR_W-1:0] ir;
    logic            stepQ;
    logic            stepEdge;
    logic            push;
    logic            stkErr;
    logic            stkErrSet;
    logic            blocked;
    logic            toFire;

    assign stepEdge = STEP & ~stepQ;
    assign pcInc    = pc + PC_W'(1);
    assign spDec    = sp - SP_W'(1);

`ifdef SEQ_ROM_TIMEOUT_EN
    localparam int TO_W = $clog2(ROM_TO + 1);

    logic [TO_W-1:0] toCnt;
    logic            timeoutQ;

    // toCnt holds the number of ACK-less FETCH cycles already completed
    assign toFire  = (state == FETCH) && !ROM_ACK && (toCnt == TO_W'(ROM_TO - 1));
    assign blocked = timeoutQ;
    assign TIMEOUT = timeoutQ;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            toCnt    <= '0;
            timeoutQ <= 1'b0;
        end else begin
            if (state == FETCH && !ROM_ACK) begin
                toCnt <= toCnt + TO_W'(1);
            end else begin
                toCnt <= '0;
            end
            if (toFire) begin
                timeoutQ <= 1'b1;
            end
        end
    end
`else
    assign toFire  = 1'b0;
    assign blocked = 1'b0;
    assign TIMEOUT = (ROM_TO < 0);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (!blocked && (RUN || stepEdge)) begin
                    nextState = FETCH;
                end
            end
            FETCH: begin
                if (ROM_ACK) begin
                    nextState = DECODE;
                end else if (toFire) begin
                    nextState = IDLE;
                end
            end
            DECODE: nextState = EXEC;
            EXEC:   nextState = RUN ? FETCH : IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Next-PC selection; RET outranks CALL, which outranks jump and skip
    always_comb begin
        nextPc    = pcInc;
        nextSp    = sp;
        push      = 1'b0;
        stkErrSet = 1'b0;
        if (RET) begin
            if (sp == '0) begin
                stkErrSet = 1'b1;
            end else begin
                nextPc = stack[spDec[IDX_W-1:0]];
                nextSp = spDec;
            end
        end else if (CALL) begin
            nextPc = JUMP_ADDR;
            if (sp == SP_W'(STACK_DEPTH)) begin
                stkErrSet = 1'b1;
            end else begin
                push   = 1'b1;
                nextSp = sp + SP_W'(1);
            end
        end else if (!nPC_LD) begin
            nextPc = JUMP_ADDR;
        end else if (!nSK_EN && SKIP_COND) begin
            nextPc = pc + PC_W'(2);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc     <= '0;
            sp     <= '0;
            ir     <= '0;
            stkErr <= 1'b0;
            stepQ  <= 1'b0;
        end else begin
            stepQ <= STEP;
            if (state == FETCH && ROM_ACK) begin
                ir <= ROM_DATA;
            end
            if (state == EXEC) begin
                pc <= nextPc;
                sp <= nextSp;
                if (stkErrSet) begin
                    stkErr <= 1'b1;
                end
            end
        end
    end

    // Stack contents need no reset; only entries below SP are ever read
    always_ff @(posedge CLK) begin
        if (state == EXEC && push) begin
            stack[sp[IDX_W-1:0]] <= pcInc;
        end
    end

    assign ROM_ADDR = pc;
    assign ROM_REQ  = (state == FETCH);
    assign IR       = ir;
    assign ST_STB   = (state == EXEC);
    assign BUSY     = (state != IDLE);
    assign STK_ERR  = stkErr;

endmodule

// File: tb/tb_ttm4_sequencer.sv
// tb/tb_ttm4_sequencer.sv - self-checking bench for ttm4_sequencer
module tb_ttm4_sequencer;

    localparam int DEPTH = 4;

    localparam int K_NOP  = 0;
    localparam int K_JMP  = 1;
    localparam int K_SKP1 = 2;
    localparam int K_SKP0 = 3;
    localparam int K_CALL = 4;
    localparam int K_RET  = 5;
    localparam int K_RC   = 6;
    localparam int K_JS   = 7;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RUN = 1'b0;
    logic        STEP = 1'b0;
    logic        ROM_ACK = 1'b0;
    logic [10:0] ROM_DATA = '0;
    logic        nPC_LD = 1'b1;
    logic        nSK_EN = 1'b1;
    logic        SKIP_COND = 1'b0;
    logic        CALL = 1'b0;
    logic        RET = 1'b0;
    logic [7:0]  JUMP_ADDR = '0;
    logic [7:0]  ROM_ADDR;
    logic        ROM_REQ;
    logic [10:0] IR;
    logic        ST_STB;
    logic        BUSY;
    logic        STK_ERR;
    logic        TIMEOUT;

    ttm4_sequencer #(.PC_W(8), .IR_W(11), .STACK_DEPTH(DEPTH), .ROM_TO(15)) dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP),
        .ROM_ADDR(ROM_ADDR), .ROM_REQ(ROM_REQ), .ROM_ACK(ROM_ACK), .ROM_DATA(ROM_DATA),
        .IR(IR), .nPC_LD(nPC_LD), .nSK_EN(nSK_EN), .SKIP_COND(SKIP_COND),
        .CALL(CALL), .RET(RET), .JUMP_ADDR(JUMP_ADDR),
        .ST_STB(ST_STB), .BUSY(BUSY), .STK_ERR(STK_ERR), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       ret;
        logic       call;
        logic       npcLd;
        logic       nskEn;
        logic       skc;
        logic [7:0] ja;
        int         dly;
        logic [7:0] expAddr;
        logic       expErr;
    } vec_t;

    vec_t       vecs [23];
    int         nVec = 0;
    int         nErr = 0;
    logic [7:0] mPc;
    logic       mErr;
    logic [7:0] mStk [$];
    logic       idleExp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic junk();
        RET       = 1'($urandom);
        CALL      = 1'($urandom);
        nPC_LD    = 1'($urandom);
        nSK_EN    = 1'($urandom);
        SKIP_COND = 1'($urandom);
        JUMP_ADDR = 8'($urandom);
    endtask

    task automatic modelReset();
        mPc = 8'h00;
        mErr = 1'b0;
        mStk.delete();
        idleExp = 1'b1;
    endtask

    // Instruction-level reference: one call per executed instruction
    task automatic modelExec(input logic ret, input logic call, input logic npcLd,
                             input logic nskEn, input logic skc, input logic [7:0] ja);
        if (ret) begin
            if (mStk.size() == 0) begin
                mPc = mPc + 8'd1;
                mErr = 1'b1;
            end else begin
                mPc = mStk.pop_back();
            end
        end else if (call) begin
            if (mStk.size() == DEPTH) mErr = 1'b1;
            else mStk.push_back(mPc + 8'd1);
            mPc = ja;
        end else if (!npcLd) begin
            mPc = ja;
        end else if (!nskEn && skc) begin
            mPc = mPc + 8'd2;
        end else begin
            mPc = mPc + 8'd1;
        end
    endtask

    function automatic vec_t mk(input int kind, input logic [7:0] ja, input int dly,
                                input logic [7:0] ea, input logic ee);
        vec_t v;
        v.ret = 1'b0; v.call = 1'b0; v.npcLd = 1'b1; v.nskEn = 1'b1; v.skc = 1'b0;
        case (kind)
            K_JMP:  v.npcLd = 1'b0;
            K_SKP1: begin v.nskEn = 1'b0; v.skc = 1'b1; end
            K_SKP0: v.nskEn = 1'b0;
            K_CALL: v.call = 1'b1;
            K_RET:  v.ret = 1'b1;
            K_RC:   begin v.ret = 1'b1; v.call = 1'b1; end
            K_JS:   begin v.npcLd = 1'b0; v.nskEn = 1'b0; v.skc = 1'b1; end
            default: ;
        endcase
        v.ja = ja; v.dly = dly; v.expAddr = ea; v.expErr = ee;
        return v;
    endfunction

    task automatic doReset();
        RUN = 1'b0; STEP = 1'b0; ROM_ACK = 1'b0;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        modelReset();
    endtask

    task automatic doInstr(input logic ret, input logic call, input logic npcLd, input logic nskEn,
                           input logic skc, input logic [7:0] ja, input int dly,
                           input logic runAfter, input logic useStep, input logic [10:0] data);
        if (idleExp) begin
            RUN = 1'b0; STEP = 1'b0; junk();
            ROM_ACK = 1'($urandom); ROM_DATA = 11'($urandom);
            tick();
            chk("idle_busy", 32'(BUSY), 32'(1'b0));
            chk("idle_req", 32'(ROM_REQ), 32'(1'b0));
            ROM_ACK = 1'b0;
            if (useStep) STEP = 1'b1;
            else RUN = 1'b1;
            tick();
            STEP = 1'b0;
        end
        chk("fetch_req", 32'(ROM_REQ), 32'(1'b1));
        chk("fetch_addr", 32'(ROM_ADDR), 32'(mPc));
        for (int d = 0; d < dly; d++) begin
            ROM_ACK = 1'b0; ROM_DATA = 11'($urandom); junk();
            tick();
            chk("req_hold", 32'(ROM_REQ), 32'(1'b1));
        end
        ROM_ACK = 1'b1; ROM_DATA = data;
        tick();
        ROM_ACK = 1'($urandom); ROM_DATA = 11'($urandom); junk();
        chk("decode_ir", 32'(IR), 32'(data));
        chk("decode_req", 32'(ROM_REQ), 32'(1'b0));
        chk("decode_stb", 32'(ST_STB), 32'(1'b0));
        tick();
        chk("exec_stb", 32'(ST_STB), 32'(1'b1));
        chk("exec_ir", 32'(IR), 32'(data));
        ROM_ACK = 1'b0;
        RET = ret; CALL = call; nPC_LD = npcLd; nSK_EN = nskEn; SKIP_COND = skc; JUMP_ADDR = ja;
        RUN = runAfter;
        tick();
        modelExec(ret, call, npcLd, nskEn, skc, ja);
        junk();
        chk("post_stb", 32'(ST_STB), 32'(1'b0));
        chk("next_addr", 32'(ROM_ADDR), 32'(mPc));
        chk("stk_err", 32'(STK_ERR), 32'(mErr));
        chk("post_busy", 32'(BUSY), 32'(runAfter));
        idleExp = !runAfter;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stbCount;

        vecs[0]  = mk(K_NOP,  8'h00, 0, 8'h01, 1'b0);
        vecs[1]  = mk(K_JMP,  8'h05, 0, 8'h05, 1'b0);
        vecs[2]  = mk(K_SKP1, 8'h00, 4, 8'h07, 1'b0);
        vecs[3]  = mk(K_JMP,  8'h05, 0, 8'h05, 1'b0);
        vecs[4]  = mk(K_SKP0, 8'h00, 0, 8'h06, 1'b0);
        vecs[5]  = mk(K_JMP,  8'h10, 0, 8'h10, 1'b0);
        vecs[6]  = mk(K_CALL, 8'h40, 0, 8'h40, 1'b0);
        vecs[7]  = mk(K_RC,   8'h77, 0, 8'h11, 1'b0);
        vecs[8]  = mk(K_JS,   8'hFE, 0, 8'hFE, 1'b0);
        vecs[9]  = mk(K_NOP,  8'h00, 0, 8'hFF, 1'b0);
        vecs[10] = mk(K_NOP,  8'h00, 0, 8'h00, 1'b0);
        vecs[11] = mk(K_JMP,  8'hFF, 0, 8'hFF, 1'b0);
        vecs[12] = mk(K_SKP1, 8'h00, 0, 8'h01, 1'b0);
        vecs[13] = mk(K_CALL, 8'h20, 0, 8'h20, 1'b0);
        vecs[14] = mk(K_CALL, 8'h30, 0, 8'h30, 1'b0);
        vecs[15] = mk(K_CALL, 8'h40, 0, 8'h40, 1'b0);
        vecs[16] = mk(K_CALL, 8'h50, 0, 8'h50, 1'b0);
        vecs[17] = mk(K_CALL, 8'h60, 0, 8'h60, 1'b1);
        vecs[18] = mk(K_RET,  8'h00, 0, 8'h41, 1'b1);
        vecs[19] = mk(K_RET,  8'h00, 0, 8'h31, 1'b1);
        vecs[20] = mk(K_RET,  8'h00, 0, 8'h21, 1'b1);
        vecs[21] = mk(K_RET,  8'h00, 0, 8'h02, 1'b1);
        vecs[22] = mk(K_RET,  8'h00, 0, 8'h03, 1'b1);

        modelReset();
        #3;
        chk("rst_req", 32'(ROM_REQ), 32'(1'b0));
        chk("rst_addr", 32'(ROM_ADDR), 32'(8'h00));
        chk("rst_ir", 32'(IR), 32'(11'h000));
        chk("rst_busy", 32'(BUSY), 32'(1'b0));
        chk("rst_stb", 32'(ST_STB), 32'(1'b0));
        chk("rst_stkerr", 32'(STK_ERR), 32'(1'b0));
        chk("rst_timeout", 32'(TIMEOUT), 32'(1'b0));
        #9;
        RST = 1'b0;
        tick();

        // Directed table, free-running except for the last entry
        for (int i = 0; i < 23; i++) begin
            doInstr(vecs[i].ret, vecs[i].call, vecs[i].npcLd, vecs[i].nskEn, vecs[i].skc,
                    vecs[i].ja, vecs[i].dly, 1'(i != 22), 1'b0, 11'($urandom));
            chk("tbl_addr", 32'(ROM_ADDR), 32'(vecs[i].expAddr));
            chk("tbl_err", 32'(STK_ERR), 32'(vecs[i].expErr));
        end

        // Single step from idle
        doInstr(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 11'h2A5);
        chk("step_addr", 32'(ROM_ADDR), 32'(8'h04));

        // STEP held high for 10 cycles executes only one instruction
        RUN = 1'b0; RET = 1'b0; CALL = 1'b0; nPC_LD = 1'b1; nSK_EN = 1'b1; SKIP_COND = 1'b0;
        tick();
        stbCount = 0;
        STEP = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ROM_ACK = ROM_REQ;
            ROM_DATA = 11'($urandom);
            tick();
            if (ST_STB) stbCount++;
            if (i == 9) STEP = 1'b0;
        end
        ROM_ACK = 1'b0;
        modelExec(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("hold_stb_count", 32'(stbCount), 32'(1));
        chk("hold_busy", 32'(BUSY), 32'(1'b0));
        chk("hold_addr", 32'(ROM_ADDR), 32'(8'h05));

        // Asynchronous reset in the middle of a fetch
        RUN = 1'b1;
        tick();
        chk("pre_rst_req", 32'(ROM_REQ), 32'(1'b1));
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_req", 32'(ROM_REQ), 32'(1'b0));
        chk("async_rst_addr", 32'(ROM_ADDR), 32'(8'h00));
        chk("async_rst_busy", 32'(BUSY), 32'(1'b0));
        chk("async_rst_err", 32'(STK_ERR), 32'(1'b0));
        RUN = 1'b0;
        tick();
        RST = 1'b0;
        modelReset();

        // Fetch with ACK withheld
        RUN = 1'b1; ROM_ACK = 1'b0;
        tick();
`ifdef SEQ_ROM_TIMEOUT_EN
        for (int i = 0; i < 14; i++) tick();
        chk("to_req_before", 32'(ROM_REQ), 32'(1'b1));
        chk("to_flag_before", 32'(TIMEOUT), 32'(1'b0));
        tick();
        chk("to_flag", 32'(TIMEOUT), 32'(1'b1));
        chk("to_req_drop", 32'(ROM_REQ), 32'(1'b0));
        chk("to_idle", 32'(BUSY), 32'(1'b0));
        tick();
        tick();
        chk("to_run_blocked", 32'(BUSY), 32'(1'b0));
        RUN = 1'b0; STEP = 1'b1;
        tick();
        tick();
        STEP = 1'b0;
        chk("to_step_blocked", 32'(BUSY), 32'(1'b0));
        chk("to_pc_kept", 32'(ROM_ADDR), 32'(8'h00));
        chk("to_sticky", 32'(TIMEOUT), 32'(1'b1));
`else
        for (int i = 0; i < 20; i++) tick();
        chk("wait_req_held", 32'(ROM_REQ), 32'(1'b1));
        chk("wait_no_timeout", 32'(TIMEOUT), 32'(1'b0));
`endif
        doReset();

        // Randomized instruction stream against the reference model
        for (int n = 0; n < 300; n++) begin
            doInstr(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 4) == 0),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                    1'($urandom), 8'($urandom), $urandom_range(0, 5),
                    1'($urandom), 1'($urandom), 11'($urandom));
        end
        chk("final_timeout", 32'(TIMEOUT), 32'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
